// File: rtl/ts_sync_receiver.sv
// MPEG2-TS receive framer: hunts for the sync byte, verifies alignment over
// several packets, then forwards framed packets with a flywheel on sync errors.
module ts_sync_receiver #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PKT_LEN      = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'h47,
    parameter int                    LOCK_COUNT   = 3,
    parameter int                    UNLOCK_COUNT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] byte_data,
    input  logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] ts_data,
    output logic                  ts_valid,
    output logic                  ts_sop,
    output logic                  ts_eop,
    output logic                  ts_sync_err,
    output logic                  locked,
    output logic [15:0]           sync_loss_cnt,
    output logic [31:0]           pkt_cnt
);

    localparam int POS_W  = $clog2(PKT_LEN);
    localparam int GOOD_W = $clog2(LOCK_COUNT);
    localparam int BAD_W  = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(PKT_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [GOOD_W-1:0]       good_q, good_d;
    logic [BAD_W-1:0]        bad_q, bad_d;
    logic [DATA_WIDTH-1:0]   ts_data_q, ts_data_d;
    logic                    ts_valid_q, ts_valid_d;
    logic                    ts_sop_q, ts_sop_d;
    logic                    ts_eop_q, ts_eop_d;
    logic                    ts_sync_err_q, ts_sync_err_d;
    logic                    locked_q, locked_d;
    logic [15:0]             sync_loss_cnt_q, sync_loss_cnt_d;
    logic [31:0]             pkt_cnt_q, pkt_cnt_d;

    logic                    is_sync;
    logic                    at_start;
    logic [POS_W-1:0]        pos_inc;

    assign is_sync  = (byte_data == SYNC_BYTE);
    assign at_start = (pos_q == '0);
    assign pos_inc  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

    always_comb begin
        state_d         = state_q;
        pos_d           = pos_q;
        good_d          = good_q;
        bad_d           = bad_q;
        ts_data_d       = ts_data_q;
        ts_valid_d      = 1'b0;
        ts_sop_d        = 1'b0;
        ts_eop_d        = 1'b0;
        ts_sync_err_d   = 1'b0;
        sync_loss_cnt_d = sync_loss_cnt_q;
        pkt_cnt_d       = pkt_cnt_q;

        if (byte_valid) begin
            case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        state_d = VERIFY;
                        pos_d   = POS_W'(1);
                        good_d  = GOOD_W'(1);
                    end
                end
                VERIFY: begin
                    pos_d = pos_inc;
                    if (at_start) begin
                        if (!is_sync) begin
                            state_d = HUNT;
                            good_d  = '0;
                        end else if (good_q == GOOD_LAST) begin
                            // The confirming sync byte opens the first forwarded packet.
                            state_d    = LOCKED;
                            bad_d      = '0;
                            ts_data_d  = byte_data;
                            ts_valid_d = 1'b1;
                            ts_sop_d   = 1'b1;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    pos_d = pos_inc;
                    if (at_start && !is_sync && bad_q == BAD_LAST) begin
                        state_d = HUNT;
                        pos_d   = '0;
                        bad_d   = '0;
                        good_d  = '0;
                        if (sync_loss_cnt_q != 16'hFFFF)
                            sync_loss_cnt_d = sync_loss_cnt_q + 16'd1;
                    end else begin
                        ts_data_d     = byte_data;
                        ts_valid_d    = 1'b1;
                        ts_sop_d      = at_start;
                        ts_eop_d      = (pos_q == POS_LAST);
                        ts_sync_err_d = at_start && !is_sync;
                        if (at_start)
                            bad_d = is_sync ? '0 : bad_q + BAD_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (ts_sop_d)
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= HUNT;
            pos_q           <= '0;
            good_q          <= '0;
            bad_q           <= '0;
            ts_data_q       <= '0;
            ts_valid_q      <= 1'b0;
            ts_sop_q        <= 1'b0;
            ts_eop_q        <= 1'b0;
            ts_sync_err_q   <= 1'b0;
            locked_q        <= 1'b0;
            sync_loss_cnt_q <= '0;
            pkt_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            pos_q           <= pos_d;
            good_q          <= good_d;
            bad_q           <= bad_d;
            ts_data_q       <= ts_data_d;
            ts_valid_q      <= ts_valid_d;
            ts_sop_q        <= ts_sop_d;
            ts_eop_q        <= ts_eop_d;
            ts_sync_err_q   <= ts_sync_err_d;
            locked_q        <= locked_d;
            sync_loss_cnt_q <= sync_loss_cnt_d;
            pkt_cnt_q       <= pkt_cnt_d;
        end
    end

    assign ts_data       = ts_data_q;
    assign ts_valid      = ts_valid_q;
    assign ts_sop        = ts_sop_q;
    assign ts_eop        = ts_eop_q;
    assign ts_sync_err   = ts_sync_err_q;
    assign locked        = locked_q;
    assign sync_loss_cnt = sync_loss_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_ts_sync_receiver.sv
// Randomized stream bench for ts_sync_receiver; expectations come from a
// packet-position model indexed by the count of valid bytes.
module tb_ts_sync_receiver;

    localparam int          PKT_LEN = 188;
    localparam int          LOCK_N  = 3;
    localparam int          UNLOCK_N = 3;
    localparam logic [7:0]  SYNC    = 8'h47;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [7:0]  ts_data;
    logic        ts_valid, ts_sop, ts_eop, ts_sync_err, locked;
    logic [15:0] sync_loss_cnt;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    ts_sync_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .ts_data       (ts_data),
        .ts_valid      (ts_valid),
        .ts_sop        (ts_sop),
        .ts_eop        (ts_eop),
        .ts_sync_err   (ts_sync_err),
        .locked        (locked),
        .sync_loss_cnt (sync_loss_cnt),
        .pkt_cnt       (pkt_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: alignment is an anchor index in the valid-byte stream.
    int         m_mode;     // 0 hunting, 1 verifying, 2 locked
    longint     m_n, m_anchor;
    int         m_good, m_bad;
    logic [7:0] e_data;
    logic       e_valid, e_sop, e_eop, e_err;
    int         e_pkt, e_loss;

    int vcount, first_sop, err_seen;

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_bad = 0;
        e_data = 8'h00; e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0;
        e_pkt = 0; e_loss = 0;
    endtask

    task automatic emit(input logic [7:0] b, input int pos, input bit err);
        e_valid = 1; e_data = b;
        e_sop = (pos == 0);
        e_eop = (pos == PKT_LEN - 1);
        e_err = err;
        if (e_sop) e_pkt++;
    endtask

    task automatic model_step(input logic [7:0] b);
        int pos;
        e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0;
        pos = (m_mode == 0) ? 0 : int'((m_n - m_anchor) % PKT_LEN);
        if (m_mode == 0) begin
            if (b == SYNC) begin m_anchor = m_n; m_good = 1; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (pos == 0) begin
                if (b != SYNC) m_mode = 0;
                else begin
                    m_good++;
                    if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; emit(b, pos, 0); end
                end
            end
        end else begin
            if (pos == 0 && b != SYNC) begin
                m_bad++;
                if (m_bad == UNLOCK_N) begin
                    m_mode = 0;
                    if (e_loss < 65535) e_loss++;
                end else emit(b, pos, 1);
            end else begin
                if (pos == 0) m_bad = 0;
                emit(b, pos, 0);
            end
        end
        m_n++;
    endtask

    task automatic cycle(input bit v, input logic [7:0] b, input bit r);
        @(negedge clk);
        byte_valid = v; byte_data = b; reset = r;
        if (r) model_reset();
        else if (v) begin model_step(b); vcount++; end
        else begin e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; end
        @(posedge clk);
        #1;
        check("ts_valid", 64'(ts_valid), 64'(e_valid));
        check("ts_sop", 64'(ts_sop), 64'(e_sop));
        check("ts_eop", 64'(ts_eop), 64'(e_eop));
        check("ts_sync_err", 64'(ts_sync_err), 64'(e_err));
        check("ts_data", 64'(ts_data), 64'(e_data));
        check("locked", 64'(locked), 64'(m_mode == 2));
        check("pkt_cnt", 64'(pkt_cnt), 64'(e_pkt));
        check("sync_loss_cnt", 64'(sync_loss_cnt), 64'(e_loss));
        if (ts_sop === 1'b1 && first_sop < 0) first_sop = vcount - 1;
        if (ts_sync_err === 1'b1) err_seen++;
    endtask

    function automatic logic [7:0] payload();
        logic [7:0] p;
        p = 8'($urandom_range(0, 255));
        if (p == SYNC) p = 8'h46;
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 3)) cycle(0, 8'($urandom), 0);
        cycle(1, b, 0);
    endtask

    task automatic send_pkt(input logic [7:0] sb, input int from, input int upto, input bit gaps);
        for (int i = from; i <= upto; i++) send_byte((i == 0) ? sb : payload(), gaps);
    endtask

    task automatic do_reset();
        cycle(0, 8'h00, 1);
        vcount = 0; first_sop = -1; err_seen = 0;
    endtask

    initial begin
        reset = 1; byte_valid = 0; byte_data = 0;
        m_n = 0; m_anchor = 0;
        model_reset();
        do_reset();
        do_reset();

        // clean aligned stream
        repeat (6) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        check("s1_first_sop_byte", 64'(first_sop), 64'd376);
        check("s1_pkt_cnt_end", 64'(pkt_cnt), 64'd4);
        check("s1_sync_err_seen", 64'(err_seen), 64'd0);
        do_reset();

        // garbage with stray sync at offset 10, true packets start at offset 50
        for (int i = 0; i < 50; i++) send_byte((i == 10) ? SYNC : payload(), 0);
        repeat (5) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        check("s2_first_sop_byte", 64'(first_sop), 64'd614);
        check("s2_pkt_cnt_end", 64'(pkt_cnt), 64'd2);
        do_reset();

        // single bad sync while locked
        repeat (4) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        send_pkt(8'h00, 0, PKT_LEN - 1, 0);
        repeat (2) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        check("s3_locked", 64'(locked), 64'd1);
        check("s3_sync_loss", 64'(sync_loss_cnt), 64'd0);
        check("s3_pkt_cnt_end", 64'(pkt_cnt), 64'd5);
        check("s3_sync_err_seen", 64'(err_seen), 64'd1);
        do_reset();

        // three consecutive bad syncs drop lock, then relock
        repeat (4) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        repeat (3) send_pkt(8'h00, 0, PKT_LEN - 1, 0);
        check("s4_unlocked", 64'(locked), 64'd0);
        repeat (4) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        check("s4_sync_loss", 64'(sync_loss_cnt), 64'd1);
        check("s4_relocked", 64'(locked), 64'd1);
        check("s4_pkt_cnt_end", 64'(pkt_cnt), 64'd6);
        check("s4_sync_err_seen", 64'(err_seen), 64'd2);
        do_reset();

        // clean stream with idle gaps
        repeat (6) send_pkt(SYNC, 0, PKT_LEN - 1, 1);
        check("s5_first_sop_byte", 64'(first_sop), 64'd376);
        check("s5_pkt_cnt_end", 64'(pkt_cnt), 64'd4);
        do_reset();

        // reset mid-packet while locked
        repeat (3) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        send_pkt(SYNC, 0, 99, 0);
        check("s6_locked_before", 64'(locked), 64'd1);
        cycle(1, payload(), 1);
        check("s6_locked_after_rst", 64'(locked), 64'd0);
        check("s6_pkt_cnt_after_rst", 64'(pkt_cnt), 64'd0);
        check("s6_valid_after_rst", 64'(ts_valid), 64'd0);
        send_pkt(SYNC, 101, PKT_LEN - 1, 0);
        repeat (2) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        check("s6_not_relocked_yet", 64'(locked), 64'd0);
        repeat (2) send_pkt(SYNC, 0, PKT_LEN - 1, 0);
        check("s6_relocked", 64'(locked), 64'd1);
        check("s6_pkt_cnt_end", 64'(pkt_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
